// File: rtl/life_pkg.sv
// life_pkg: shared types and constants for the Game-of-Life step engine.
//   state_e   - step FSM states (idle / running rows / publishing result)
//   rule_t    - 9-bit birth/survive rule, bit n = outcome for n live neighbours
//   NbrCntW   - width of a neighbour count (0..8)
package life_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    typedef logic [8:0] rule_t;

    localparam int unsigned NbrCntW = 4;

    typedef logic [NbrCntW-1:0] nbr_cnt_t;

endpackage

// File: rtl/life_step_engine_if.sv
// life_step_engine_if: request/result bundle for life_step_engine.
//   start, birth, survive, board_in      - request side (driven by master)
//   busy, done, board_out, gen_count     - result side (driven by slave)
//   pop_count                            - live-cell count, only with LIFE_POPCOUNT_EN
// Board cell (r,c) lives at bit r*W+c.
interface life_step_engine_if
    import life_pkg::*;
#(
    parameter int unsigned W = 32,
    parameter int unsigned H = 24
);
    logic           start;
    rule_t          birth;
    rule_t          survive;
    logic [W*H-1:0] board_in;
    logic           busy;
    logic           done;
    logic [W*H-1:0] board_out;
    logic [31:0]    gen_count;
`ifdef LIFE_POPCOUNT_EN
    logic [$clog2(W*H+1)-1:0] pop_count;

    modport master (
        output start, birth, survive, board_in,
        input  busy, done, board_out, gen_count, pop_count
    );
    modport slave (
        input  start, birth, survive, board_in,
        output busy, done, board_out, gen_count, pop_count
    );
`else
    modport master (
        output start, birth, survive, board_in,
        input  busy, done, board_out, gen_count
    );
    modport slave (
        input  start, birth, survive, board_in,
        output busy, done, board_out, gen_count
    );
`endif
endinterface

// File: rtl/life_row_eval.sv
// life_row_eval: combinational next-state for one board row.
//   row_up_i / row_mid_i / row_dn_i - rows above, current, below (already
//                                     zeroed by the caller for dead edges)
//   birth_i / survive_i             - rule bits indexed by neighbour count
//   row_next_o                      - next generation of row_mid_i
// TORUS selects whether columns wrap (1) or read as dead beyond the edge (0).
module life_row_eval
    import life_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned TORUS = 1
) (
    input  logic [W-1:0] row_up_i,
    input  logic [W-1:0] row_mid_i,
    input  logic [W-1:0] row_dn_i,
    input  rule_t        birth_i,
    input  rule_t        survive_i,
    output logic [W-1:0] row_next_o
);

    // Sum of the 8 neighbours of column c; cc = -1 marks a dead off-board column.
    function automatic nbr_cnt_t count_at(input logic [W-1:0] up, input logic [W-1:0] mid,
                                          input logic [W-1:0] dn, input int c);
        nbr_cnt_t cnt;
        int       cc;
        cnt = '0;
        for (int dc = -1; dc <= 1; dc++) begin
            cc = c + dc;
            if (cc < 0) begin
                cc = (TORUS != 0) ? int'(W) - 1 : -1;
            end else if (cc >= int'(W)) begin
                cc = (TORUS != 0) ? 0 : -1;
            end
            if (cc >= 0) begin
                cnt = cnt + nbr_cnt_t'(up[cc]) + nbr_cnt_t'(dn[cc]);
                if (dc != 0) begin
                    cnt = cnt + nbr_cnt_t'(mid[cc]);
                end
            end
        end
        return cnt;
    endfunction

    for (genvar c = 0; c < int'(W); c++) begin : g_col
        nbr_cnt_t cnt;
        assign cnt = count_at(row_up_i, row_mid_i, row_dn_i, c);
        // Count indexes the rule directly: bit 0 means "no live neighbours".
        assign row_next_o[c] = row_mid_i[c] ? survive_i[cnt] : birth_i[cnt];
    end

endmodule

// File: rtl/life_step_engine.sv
// life_step_engine: computes one Game-of-Life generation, one row per cycle.
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   bus       - life_step_engine_if.slave: start/birth/survive/board_in in,
//               busy/done/board_out/gen_count out
// A start accepted in idle snapshots the board and rules, then H run cycles fill
// a shadow board; the done cycle copies it to board_out so partial rows never show.
// Optional feature: define LIFE_POPCOUNT_EN to add bus.pop_count (live cells in
// board_out), accumulated row by row during the run.
module life_step_engine
    import life_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned H     = 24,
    parameter int unsigned TORUS = 1
) (
    input  logic              clk,
    input  logic              rst,
    life_step_engine_if.slave bus
);

    localparam int unsigned N    = W * H;
    localparam int unsigned RowW = (H > 1) ? $clog2(H) : 1;

    state_e          state_q,     state_d;
    logic [RowW-1:0] row_q,       row_d;
    logic [N-1:0]    board_q,     board_d;
    rule_t           birth_q,     birth_d;
    rule_t           survive_q,   survive_d;
    logic [N-1:0]    next_q,      next_d;
    logic [N-1:0]    board_out_q, board_out_d;
    logic [31:0]     gen_count_q, gen_count_d;
    logic            busy_q,      busy_d;
    logic            done_q,      done_d;

`ifdef LIFE_POPCOUNT_EN
    localparam int unsigned PopW = $clog2(W * H + 1);
    logic [PopW-1:0] pop_acc_q,   pop_acc_d;
    logic [PopW-1:0] pop_count_q, pop_count_d;
`endif

    logic [RowW-1:0] row_up_idx, row_dn_idx;
    logic            up_valid, dn_valid;
    logic [W-1:0]    row_up, row_mid, row_dn, row_next;

    // Neighbour rows of the row under evaluation; off-board rows read as dead
    // unless the board wraps.
    always_comb begin
        row_up_idx = (row_q == '0) ? RowW'(H - 1) : row_q - RowW'(1);
        row_dn_idx = (row_q == RowW'(H - 1)) ? '0 : row_q + RowW'(1);
        up_valid   = (TORUS != 0) || (row_q != '0);
        dn_valid   = (TORUS != 0) || (row_q != RowW'(H - 1));
        row_mid    = board_q[row_q * W +: W];
        row_up     = up_valid ? board_q[row_up_idx * W +: W] : '0;
        row_dn     = dn_valid ? board_q[row_dn_idx * W +: W] : '0;
    end

    life_row_eval #(
        .W     (W),
        .TORUS (TORUS)
    ) u_row_eval (
        .row_up_i   (row_up),
        .row_mid_i  (row_mid),
        .row_dn_i   (row_dn),
        .birth_i    (birth_q),
        .survive_i  (survive_q),
        .row_next_o (row_next)
    );

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        board_d     = board_q;
        birth_d     = birth_q;
        survive_d   = survive_q;
        next_d      = next_q;
        board_out_d = board_out_q;
        gen_count_d = gen_count_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef LIFE_POPCOUNT_EN
        pop_acc_d   = pop_acc_q;
        pop_count_d = pop_count_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StRun;
                    row_d     = '0;
                    board_d   = bus.board_in;
                    birth_d   = bus.birth;
                    survive_d = bus.survive;
                    busy_d    = 1'b1;
`ifdef LIFE_POPCOUNT_EN
                    pop_acc_d = '0;
`endif
                end
            end
            StRun: begin
                next_d[row_q * W +: W] = row_next;
`ifdef LIFE_POPCOUNT_EN
                pop_acc_d = pop_acc_q + PopW'($countones(row_next));
`endif
                if (row_q == RowW'(H - 1)) begin
                    state_d = StDone;
                end else begin
                    row_d = row_q + RowW'(1);
                end
            end
            StDone: begin
                state_d     = StIdle;
                board_out_d = next_q;
                gen_count_d = gen_count_q + 32'd1;
                busy_d      = 1'b0;
                done_d      = 1'b1;
`ifdef LIFE_POPCOUNT_EN
                pop_count_d = pop_acc_q;
`endif
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            row_q       <= '0;
            board_q     <= '0;
            birth_q     <= '0;
            survive_q   <= '0;
            next_q      <= '0;
            board_out_q <= '0;
            gen_count_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef LIFE_POPCOUNT_EN
            pop_acc_q   <= '0;
            pop_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            board_q     <= board_d;
            birth_q     <= birth_d;
            survive_q   <= survive_d;
            next_q      <= next_d;
            board_out_q <= board_out_d;
            gen_count_q <= gen_count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef LIFE_POPCOUNT_EN
            pop_acc_q   <= pop_acc_d;
            pop_count_q <= pop_count_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.board_out = board_out_q;
    assign bus.gen_count = gen_count_q;
`ifdef LIFE_POPCOUNT_EN
    assign bus.pop_count = pop_count_q;
`endif

endmodule

// File: tb/tb_life_step_engine.sv
// tb_life_step_engine: directed checks of life_step_engine on an 8x6 board.
// Two engines run in lockstep: dut_t wraps (TORUS=1), dut_p has dead edges.
// Define LIFE_POPCOUNT_EN to also check pop_count.
module tb_life_step_engine;
    import life_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned H = 6;
    localparam int unsigned N = W * H;

    localparam rule_t B3  = 9'h008;
    localparam rule_t S23 = 9'h00c;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    life_step_engine_if #(.W(W), .H(H)) bus_t ();
    life_step_engine_if #(.W(W), .H(H)) bus_p ();

    life_step_engine #(.W(W), .H(H), .TORUS(1)) dut_t (
        .clk (clk),
        .rst (rst),
        .bus (bus_t)
    );

    life_step_engine #(.W(W), .H(H), .TORUS(0)) dut_p (
        .clk (clk),
        .rst (rst),
        .bus (bus_p)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Row r occupies bits r*8+7..r*8; bit 0 of each byte is column 0.
    function automatic logic [N-1:0] mk(input logic [7:0] r0, input logic [7:0] r1,
                                        input logic [7:0] r2, input logic [7:0] r3,
                                        input logic [7:0] r4, input logic [7:0] r5);
        return {r5, r4, r3, r2, r1, r0};
    endfunction

    logic [N-1:0] blink_h, blink_v, glider, glider_t4, block_edge, block_c, all_ones;

    task automatic set_inputs(input logic [N-1:0] bt, input logic [N-1:0] bp,
                              input rule_t b, input rule_t s);
        bus_t.board_in = bt;
        bus_p.board_in = bp;
        bus_t.birth    = b;
        bus_p.birth    = b;
        bus_t.survive  = s;
        bus_p.survive  = s;
    endtask

    task automatic set_start(input logic v);
        bus_t.start = v;
        bus_p.start = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_start(1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_step(input string tag);
        int lat;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        check_eq({tag, "_busy"}, 64'(bus_t.busy), 64'd1);
        lat = -1;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(negedge clk);
            if (bus_t.done) lat = i;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(H + 1));
    endtask

    initial begin
        int dones;
        blink_h    = mk(8'h00, 8'h00, 8'h38, 8'h00, 8'h00, 8'h00);
        blink_v    = mk(8'h00, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00);
        glider     = mk(8'h40, 8'h80, 8'he0, 8'h00, 8'h00, 8'h00);
        glider_t4  = mk(8'h00, 8'h80, 8'h01, 8'hc1, 8'h00, 8'h00);
        block_edge = mk(8'h00, 8'h00, 8'hc0, 8'hc0, 8'h00, 8'h00);
        block_c    = mk(8'h00, 8'h00, 8'h0c, 8'h0c, 8'h00, 8'h00);
        all_ones   = '1;

        set_inputs('0, '0, B3, S23);
        @(negedge clk);
        do_reset();
        check_eq("rst_busy", 64'(bus_t.busy), 64'd0);
        check_eq("rst_done", 64'(bus_t.done), 64'd0);
        check_eq("rst_board", 64'(bus_t.board_out), 64'd0);
        check_eq("rst_gen", 64'(bus_t.gen_count), 64'd0);

        // Reset beats a simultaneous start.
        set_inputs(blink_h, blink_h, B3, S23);
        rst = 1'b1;
        set_start(1'b1);
        @(negedge clk);
        rst = 1'b0;
        set_start(1'b0);
        check_eq("rst_prio_busy", 64'(bus_t.busy), 64'd0);
        repeat (H + 3) @(negedge clk);
        check_eq("rst_prio_gen", 64'(bus_t.gen_count), 64'd0);

        // Blinker: horizontal -> vertical.
        run_step("blink");
        check_eq("blink_t", 64'(bus_t.board_out), 64'(blink_v));
        check_eq("blink_p", 64'(bus_p.board_out), 64'(blink_v));
        check_eq("blink_gen", 64'(bus_t.gen_count), 64'd1);
        check_eq("blink_busy_done", 64'(bus_t.busy), 64'd0);
`ifdef LIFE_POPCOUNT_EN
        check_eq("blink_pop", 64'(bus_t.pop_count), 64'd3);
`endif
        @(negedge clk);
        check_eq("blink_done_pulse", 64'(bus_t.done), 64'd0);
        check_eq("blink_hold", 64'(bus_t.board_out), 64'(blink_v));

        // Still-life block.
        set_inputs(block_c, block_c, B3, S23);
        run_step("block");
        check_eq("block_t", 64'(bus_t.board_out), 64'(block_c));
        check_eq("block_gen", 64'(bus_t.gen_count), 64'd2);
`ifdef LIFE_POPCOUNT_EN
        check_eq("block_pop", 64'(bus_t.pop_count), 64'd4);
`endif

        // Zero-neighbour birth rule.
        set_inputs('0, '0, 9'h001, 9'h000);
        run_step("zero_b0");
        check_eq("zero_b0_t", 64'(bus_t.board_out), 64'(all_ones));
        check_eq("zero_b0_p", 64'(bus_p.board_out), 64'(all_ones));
        set_inputs('0, '0, 9'h000, 9'h000);
        run_step("zero_nb0");
        check_eq("zero_nb0_t", 64'(bus_t.board_out), 64'd0);
        check_eq("zero_nb0_p", 64'(bus_p.board_out), 64'd0);

        // Glider at the right edge, fed back step by step (back-to-back starts).
        do_reset();
        set_inputs(glider, glider, B3, S23);
        run_step("glider1");
        for (int g = 2; g <= 4; g++) begin
            set_inputs(bus_t.board_out, bus_p.board_out, B3, S23);
            run_step("glider_n");
        end
        check_eq("glider_torus", 64'(bus_t.board_out), 64'(glider_t4));
        check_eq("glider_gen", 64'(bus_t.gen_count), 64'd4);
        set_inputs(bus_t.board_out, bus_p.board_out, B3, S23);
        run_step("glider5");
        check_eq("glider_edge_block", 64'(bus_p.board_out), 64'(block_edge));
        set_inputs(bus_t.board_out, bus_p.board_out, B3, S23);
        run_step("glider6");
        check_eq("glider_edge_stable", 64'(bus_p.board_out), 64'(block_edge));

        // Start while busy is dropped; board_in change mid-step is ignored.
        do_reset();
        set_inputs(blink_h, blink_h, B3, S23);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        set_inputs(glider, glider, B3, S23);
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_t.done) dones++;
        end
        check_eq("busy_start_dones", 64'(dones), 64'd1);
        check_eq("busy_start_board", 64'(bus_t.board_out), 64'(blink_v));
        check_eq("busy_start_gen", 64'(bus_t.gen_count), 64'd1);

        // Reset in the middle of a run aborts it.
        do_reset();
        set_inputs(blink_h, blink_h, B3, S23);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        repeat (H / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 2 * H; i++) begin
            @(negedge clk);
            if (bus_t.done) dones++;
        end
        check_eq("abort_dones", 64'(dones), 64'd0);
        check_eq("abort_board", 64'(bus_t.board_out), 64'd0);
        check_eq("abort_gen", 64'(bus_t.gen_count), 64'd0);
        check_eq("abort_busy", 64'(bus_t.busy), 64'd0);
        run_step("after_abort");
        check_eq("after_abort_board", 64'(bus_t.board_out), 64'(blink_v));
        check_eq("after_abort_gen", 64'(bus_t.gen_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
